// File: rtl/keypad_if.sv
// keypad_if: groups the keypad matrix pins and the decoded-key outputs.
//
// Signals
//   cols      - keypad columns, active-low, asynchronous to clk
//   rows      - keypad rows, active-low, exactly one low at a time
//   key       - hex code of the last accepted key
//   key_valid - one-cycle pulse per accepted press
//   key_held  - high from acceptance until the release is accepted
//
// Handshake: key_valid is a push-only strobe with no ready/backpressure.
// The consumer must take key on the single cycle key_valid is high. key
// stays stable afterwards, so a late reader still sees the last key.
//
// Modports
//   master - the scanner: drives rows and the key outputs, reads cols
//   slave  - the keypad/consumer side: drives cols, reads everything else
interface keypad_if;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (input cols, output rows, output key, output key_valid, output key_held);
  modport slave  (output cols, input rows, input key, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and reports debounced
// presses as a 4-bit hex code with a one-cycle strobe.
//
// Ports
//   clk     - system clock
//   reset   - synchronous, active-high reset
//   kp      - keypad_if.master (cols in; rows, key, key_valid, key_held out)
//   state_o - current FSM state for debug (0 SCAN, 1 DEBOUNCE, 2 HELD)
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  keypad_if.master   kp,
  output logic [1:0] state_o
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  state_e        state_q;
  logic [3:0]    meta_q;
  logic [3:0]    scol_q;
  logic [1:0]    row_q;
  logic [3:0]    rows_q;
  logic [DW-1:0] dwell_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    cap_pat_q;
  logic [1:0]    cap_col_q;
  logic [3:0]    key_q;
  logic          valid_q;
  logic          held_q;

  logic [3:0]    low_d;
  logic          one_low_d;
  logic [1:0]    scol_idx_d;
  logic [1:0]    row_nxt_d;
  logic [3:0]    rows_nxt_d;
  logic [3:0]    key_d;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  always_comb begin
    low_d      = ~scol_q;
    // Exactly one column low: nonzero and a power of two.
    one_low_d  = (low_d != 4'd0) && ((low_d & (low_d - 4'd1)) == 4'd0);
    scol_idx_d = 2'd0;
    if      (!scol_q[0]) scol_idx_d = 2'd0;
    else if (!scol_q[1]) scol_idx_d = 2'd1;
    else if (!scol_q[2]) scol_idx_d = 2'd2;
    else if (!scol_q[3]) scol_idx_d = 2'd3;
    row_nxt_d  = row_q + 2'd1;
    rows_nxt_d = ~(4'b0001 << row_nxt_d);
    key_d      = key_code(row_q, cap_col_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      meta_q    <= 4'hF;
      scol_q    <= 4'hF;
      row_q     <= 2'd0;
      rows_q    <= 4'b1110;
      dwell_q   <= '0;
      cnt_q     <= '0;
      cap_pat_q <= 4'hF;
      cap_col_q <= 2'd0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      meta_q  <= kp.cols;
      scol_q  <= meta_q;
      valid_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (one_low_d) begin
              // Row stays driven; DEBOUNCE re-checks this exact pattern.
              cap_pat_q <= scol_q;
              cap_col_q <= scol_idx_d;
              cnt_q     <= '0;
              state_q   <= ST_DEBOUNCE;
            end else begin
              row_q  <= row_nxt_d;
              rows_q <= rows_nxt_d;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (scol_q == cap_pat_q) begin
            if (cnt_q == CNT_LAST) begin
              key_q   <= key_d;
              valid_q <= 1'b1;
              held_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_HELD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q   <= '0;
            dwell_q <= '0;
            row_q   <= row_nxt_d;
            rows_q  <= rows_nxt_d;
            state_q <= ST_SCAN;
          end
        end
        ST_HELD: begin
          // Only an all-ones column read counts toward release; any low bit
          // (same key or another key in this row) restarts the count.
          if (scol_q == 4'hF) begin
            if (cnt_q == CNT_LAST) begin
              held_q  <= 1'b0;
              cnt_q   <= '0;
              dwell_q <= '0;
              row_q   <= row_nxt_d;
              rows_q  <= rows_nxt_d;
              state_q <= ST_SCAN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign kp.rows      = rows_q;
  assign kp.key       = key_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  localparam int SC = 4;
  localparam int DB = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  keypad_if kp_if();

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
    .clk    (clk),
    .reset  (reset),
    .kp     (kp_if),
    .state_o(state_dbg)
  );

  // ---------------- keypad model ----------------
  logic [15:0] pressed = '0;  // bit r*4+c
  always_comb begin
    logic [3:0] c_v;
    c_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp_if.rows[r]) c_v[c] = 1'b0;
    kp_if.cols = c_v;
  end

  // ---------------- scoreboard counters ----------------
  int unsigned passed = 0;
  int unsigned total  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [3:0] kmap [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] m_hist [$] = '{4'hF, 4'hF};  // cols seen at the last two edges
  int         t = 0;
  int         m_mode = 0;                  // 0 scanning, 1 debouncing, 2 held
  int         m_r0 = 0, m_t0 = 0;          // scanning: start row and start edge
  int         m_row = 0, m_col = 0;
  logic [3:0] m_pat = 4'hF;
  int         m_stable = 0;
  logic [3:0] e_rows = 4'b1110, e_key = 4'h0;
  logic       e_valid = 1'b0, e_held = 1'b0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin : model
    logic [3:0] s;
    int k;
    int cur_row;
    t++;
    if (reset) begin
      m_mode = 0; m_r0 = 0; m_t0 = t; m_stable = 0;
      e_key = 4'h0; e_valid = 1'b0; e_held = 1'b0;
      m_hist = '{4'hF, 4'hF};
    end else begin
      s = m_hist.pop_front();
      m_hist.push_back(kp_if.cols);
      e_valid = 1'b0;
      case (m_mode)
        0: begin
          k = t - m_t0;
          if (k > 0 && (k % SC) == 0 && $countones(~s) == 1) begin
            m_row = (m_r0 + k / SC - 1) % 4;
            for (int c = 0; c < 4; c++) if (!s[c]) m_col = c;
            m_pat = s; m_stable = 0; m_mode = 1;
          end
        end
        1: begin
          if (s == m_pat) begin
            m_stable++;
            if (m_stable == DB) begin
              e_key = kmap[m_row*4 + m_col];
              e_valid = 1'b1; e_held = 1'b1;
              m_mode = 2; m_stable = 0;
            end
          end else begin
            m_mode = 0; m_r0 = (m_row + 1) % 4; m_t0 = t; m_stable = 0;
          end
        end
        default: begin
          if (s == 4'hF) m_stable++;
          else m_stable = 0;
          if (m_stable == DB) begin
            e_held = 1'b0; m_mode = 0; m_r0 = (m_row + 1) % 4; m_t0 = t; m_stable = 0;
          end
        end
      endcase
    end
    cur_row = (m_mode == 0) ? (m_r0 + (t - m_t0) / SC) % 4 : m_row;
    e_rows = ~(4'b0001 << cur_row);
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("rows", {28'd0, kp_if.rows}, {28'd0, e_rows});
      check("key", {28'd0, kp_if.key}, {28'd0, e_key});
      check("key_valid", {31'd0, kp_if.key_valid}, {31'd0, e_valid});
      check("key_held", {31'd0, kp_if.key_held}, {31'd0, e_held});
      check("state", {30'd0, state_dbg}, m_mode);
    end
  end

  // pulse monitor for the hand-computed expectations
  int         pulses = 0;
  logic [3:0] last_key = 4'h0;
  always @(negedge clk) begin
    if (kp_if.key_valid) begin
      pulses++;
      last_key = kp_if.key;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int max, output bit got);
    int p0;
    p0 = pulses;
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (pulses != p0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rows"}, {28'd0, kp_if.rows}, 32'h0000_000E);
    check({tag, "_key"}, {28'd0, kp_if.key}, 32'd0);
    check({tag, "_valid"}, {31'd0, kp_if.key_valid}, 32'd0);
    check({tag, "_held"}, {31'd0, kp_if.key_held}, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int p0;
    bit got;
    logic [3:0] r_a;

    reset = 1'b1;
    pressed = '0;
    tick(3);
    chk_en = 1'b1;
    check_reset_vals("reset");
    reset = 1'b0;

    // 1: idle scanning
    p0 = pulses;
    tick(200);
    check("t1_no_pulse", pulses - p0, 0);
    check("t1_key", {28'd0, kp_if.key}, 32'd0);
    check("t1_held", {31'd0, kp_if.key_held}, 32'd0);
    r_a = kp_if.rows;
    tick(SC);
    check("t1_row_rotate", {28'd0, kp_if.rows}, {28'd0, r_a[2:0], r_a[3]});

    // 2: press r1/c1 and hold
    tick($urandom_range(0, 7));
    p0 = pulses;
    pressed[1*4+1] = 1'b1;
    wait_pulse(60, got);
    check("t2_pulse_seen", {31'd0, got}, 32'd1);
    check("t2_key", {28'd0, last_key}, 32'h5);
    check("t2_held_rise", {31'd0, kp_if.key_held}, 32'd1);
    tick(50);
    check("t2_rows_frozen", {28'd0, kp_if.rows}, 32'hD);
    check("t2_held_stay", {31'd0, kp_if.key_held}, 32'd1);
    check("t2_one_pulse", pulses - p0, 1);
    pressed = '0;
    tick(30);
    check("t2_held_fall", {31'd0, kp_if.key_held}, 32'd0);

    // 3: bounce r2/c0 then stable
    p0 = pulses;
    repeat (4) begin
      pressed[2*4+0] = 1'b1; tick(5);
      pressed[2*4+0] = 1'b0; tick(3);
    end
    check("t3_no_bounce_pulse", pulses - p0, 0);
    pressed[2*4+0] = 1'b1;
    wait_pulse(60, got);
    check("t3_pulse_seen", {31'd0, got}, 32'd1);
    check("t3_key", {28'd0, last_key}, 32'h7);
    pressed = '0;
    tick(30);
    check("t3_one_pulse", pulses - p0, 1);

    // 4: two keys on one row, then one released
    p0 = pulses;
    pressed[0] = 1'b1;
    pressed[3] = 1'b1;
    tick(60);
    check("t4_no_dual_pulse", pulses - p0, 0);
    pressed[3] = 1'b0;
    wait_pulse(60, got);
    check("t4_pulse_seen", {31'd0, got}, 32'd1);
    check("t4_key", {28'd0, last_key}, 32'h1);
    pressed = '0;
    tick(30);

    // 5: second key on another row while held
    pressed[3*4+1] = 1'b1;
    wait_pulse(60, got);
    check("t5_pulse_seen", {31'd0, got}, 32'd1);
    check("t5_key0", {28'd0, last_key}, 32'h0);
    p0 = pulses;
    pressed[1*4+2] = 1'b1;
    tick(60);
    check("t5_no_second", pulses - p0, 0);
    check("t5_held", {31'd0, kp_if.key_held}, 32'd1);
    pressed = '0;
    tick(30);
    check("t5_released", {31'd0, kp_if.key_held}, 32'd0);
    pressed[1*4+2] = 1'b1;
    wait_pulse(60, got);
    check("t5_pulse2_seen", {31'd0, got}, 32'd1);
    check("t5_key6", {28'd0, last_key}, 32'h6);
    pressed = '0;
    tick(30);

    // 6: reset during DEBOUNCE
    pressed[2*4+3] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (m_mode == 1) begin
        got = 1'b1;
        break;
      end
    end
    check("t6_reached_debounce", {31'd0, got}, 32'd1);
    tick(3);
    p0 = pulses;
    reset = 1'b1;
    tick(2);
    check_reset_vals("t6_reset");
    check("t6_no_pulse", pulses - p0, 0);
    reset = 1'b0;
    wait_pulse(4*SC + 11, got);
    check("t6_pulse_seen", {31'd0, got}, 32'd1);
    check("t6_keyC", {28'd0, last_key}, 32'hC);
    check("t6_one_pulse", pulses - p0, 1);
    pressed = '0;
    tick(30);

    // random presses, chords, bounces and occasional resets
    repeat (16) begin
      pressed[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      tick($urandom_range(1, 60));
      if ($urandom_range(0, 3) == 0) begin
        pressed = '0;
        tick($urandom_range(1, 6));
        pressed[$urandom_range(0, 15)] = 1'b1;
        tick($urandom_range(1, 40));
      end
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      pressed = '0;
      tick($urandom_range(0, 40));
    end
    tick(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad and reports debounced key presses as a 4-bit hex code plus a one-cycle strobe. It is the input end of the hex-digit path: its `key` output feeds the 4-bit input of the seven-segment decoder, replacing the DIP switches.

## Interface
- `SCAN_CYCLES`, default 1000: clocks each row is driven before the columns are sampled. Must be at least 3.
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable clocks required to accept a press, and again to accept a release. Must be at least 1.
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `cols`, in, 4: keypad columns, active-low, externally pulled up, asynchronous to `clk`.
- `rows`, out, 4: keypad rows, active-low. Exactly one bit is low at all times.
- `key`, out, 4: hex code of the last accepted key.
- `key_valid`, out, 1: one-cycle pulse when a new press is accepted.
- `key_held`, out, 1: high from acceptance until the release is accepted.

## Operation
- `cols` passes through a 2-flop synchronizer. All decisions use the synchronized value `scol`.
- Key map (row r drives low, col c reads low):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- The FSM has three states.
- **SCAN**
  - The row index advances 0→1→2→3→0 every `SCAN_CYCLES` clocks.
  - `scol` is sampled on the last dwell clock of each row.
  - If exactly one bit of `scol` is low: capture the row and column, then go to DEBOUNCE. The row stays driven.
  - If zero bits or two or more bits are low: no capture. Scanning continues with the next row.
- **DEBOUNCE**
  - Each clock where `scol` equals the captured one-hot-low pattern increments `cnt`.
  - On reaching `DEBOUNCE_CYCLES`: register `key`, pulse `key_valid`, set `key_held`, clear `cnt`, go to HELD.
  - Any mismatch clears `cnt` and returns to SCAN. The dwell counter is zeroed and scanning resumes at the next row.
- **HELD**
  - The row stays driven.
  - Each clock with `scol` == 4'b1111 increments `cnt`. Any low bit clears `cnt`.
  - On reaching `DEBOUNCE_CYCLES`: clear `key_held`, go to SCAN at the next row.
  - Presses on other rows while in HELD are invisible and are ignored. A second key in the same row while held is ignored. Only a full release ends HELD.
- `key` holds its value until the next acceptance. It is not cleared on release.
- Counter widths are sized with `$clog2` of the parameter values. Counters saturate-free: they clear on transition, so no wrap-around is possible.

## Timing
- Reset values (all taking effect on the first edge with `reset` high):
  - `rows` = 4'b1110
  - `key` = 4'h0
  - `key_valid` = 0
  - `key_held` = 0
  - state = SCAN
  - all counters and synchronizer flops cleared (synchronizer flops to 1)
- `reset` has priority over every event, including mid-DEBOUNCE and mid-HELD. No `key_valid` is produced for an interrupted press.
- Row dwell: a row is low for exactly `SCAN_CYCLES` clocks in SCAN. The sample occurs `SCAN_CYCLES-1` clocks after the row change. This covers the 2-cycle synchronizer delay given `SCAN_CYCLES` ≥ 3.
- Press latency, from `cols` going low until `key_valid`:
  - synchronizer: 2 clocks
  - plus wait until the sample point of that row
  - plus `DEBOUNCE_CYCLES` clocks
  - plus 1 register clock
- `key`, `key_valid` and the `key_held` rise all update on the same edge. `key_valid` is high for exactly 1 clock per accepted press.
- `key_held` falls `DEBOUNCE_CYCLES` clocks after `scol` first reads all-ones continuously.
- Release and capture on the same row boundary is not possible: after HELD, the first sample is a full dwell later.

## Test plan
The bench keypad model drives `cols[c] = ~(pressed && rows[r]==0)`. Parameters are `SCAN_CYCLES`=4 and `DEBOUNCE_CYCLES`=8.
1. Reset then idle 200 clocks → `rows` cycles 1110,1101,1011,0111 every 4 clocks; `key_valid` never high; `key`=0; `key_held`=0.
2. Press r1/c1 and hold 100 clocks → exactly one `key_valid` pulse with `key`=4'h5. `key_held` rises with the pulse and stays high while held, with `rows` frozen at 1101. After release, `key_held` falls 8 clocks after `scol` reads 1111 and scanning resumes.
3. Bounce r2/c0, low 5 clocks then high 3, repeated 4 times, then stable low → no pulse during bouncing; a single pulse with `key`=4'h7 after 8 stable clocks.
4. Press r0/c0 and r0/c3 together → never accepted, no `key_valid`. Release c3 → `key`=4'h1 accepted.
5. Hold r3/c1 (`key`=0), then add r1/c2 → no second pulse. Release both, then press r1/c2 → `key`=4'h6.
6. Press r2/c3, assert `reset` 4 clocks into DEBOUNCE → no `key_valid`; all outputs at reset values. With the key still held after `reset` drops, a pulse with `key`=4'hC follows within one scan period plus 11 clocks.
